fifo_drain_serializer: RTL

- Read-side consumer for the 64-bit, 16-entry pipeline FIFO. It pops entries through the FIFO's rd/data_out/fifo_empty interface.
- Each entry is split into IN_W/OUT_W narrow words and presented on a valid/ready stream to the RV32IM core's load/peripheral path.
- A holding register with same-cycle refill gives zero-bubble streaming when the FIFO stays non-empty.

---
 rtl/fifo_drain_serializer_if.sv | 26 ++
 rtl/fifo_drain_serializer.sv | 111 +++++++++++
 2 files changed

// File: rtl/fifo_drain_serializer_if.sv
// Bundle between the FIFO read port, the serializer, and the narrow output stream.
// master = serializer side, slave = FIFO/consumer side.
interface fifo_drain_serializer_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32
);
  logic             enable_i;
  logic             fifo_empty_i;
  logic [IN_W-1:0]  fifo_data_i;
  logic             fifo_rd_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] out_data_o;
  logic             out_last_o;
  logic             busy_o;

  modport master (
    input  enable_i, fifo_empty_i, fifo_data_i, out_ready_i,
    output fifo_rd_o, out_valid_o, out_data_o, out_last_o, busy_o
  );

  modport slave (
    output enable_i, fifo_empty_i, fifo_data_i, out_ready_i,
    input  fifo_rd_o, out_valid_o, out_data_o, out_last_o, busy_o
  );
endinterface

// File: rtl/fifo_drain_serializer.sv
// Pops wide FIFO entries and streams them as IN_W/OUT_W narrow beats on valid/ready.
// Optional DRAIN_FLUSH_EN adds flush_i to discard the held entry.
module fifo_drain_serializer #(
  parameter int IN_W      = 64,
  parameter int OUT_W     = 32,
  parameter int MSW_FIRST = 0
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DRAIN_FLUSH_EN
  input  logic flush_i,
`endif
  fifo_drain_serializer_if.master bus
);

  localparam int BEATS = IN_W / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (IN_W % OUT_W != 0) begin : g_width_chk
    $error("IN_W must be a multiple of OUT_W");
  end

  typedef enum logic {EMPTY, SENDING} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d, beat_nxt;
  logic [IN_W-1:0]  hold_q, hold_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             rd_q, rd_d;
  logic             valid, xfer, at_last, load, flush;

`ifdef DRAIN_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Beat k maps to word k, or word BEATS-1-k when the MSW goes first.
  function automatic logic [OUT_W-1:0] pick(input logic [IN_W-1:0] v, input logic [BW-1:0] k);
    logic [BEATS-1:0][OUT_W-1:0] w;
    w    = v;
    pick = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (k == BW'((MSW_FIRST != 0) ? (BEATS - 1 - i) : i)) pick = w[i];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      beat_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    hold_d   = hold_q;
    data_d   = data_q;
    last_d   = last_q;
    rd_d     = 1'b0;
    valid    = (state_q == SENDING);
    xfer     = valid & bus.out_ready_i;
    at_last  = (beat_q == LAST_BEAT);
    beat_nxt = beat_q + BW'(1);
    // Refill in the same cycle the last beat leaves, so back-to-back entries have no bubble.
    load     = bus.enable_i & ~bus.fifo_empty_i & (~valid | (xfer & at_last));

    if (flush) begin
      state_d = EMPTY;
      beat_d  = '0;
      last_d  = 1'b0;
    end else if (load) begin
      state_d = SENDING;
      hold_d  = bus.fifo_data_i;
      beat_d  = '0;
      data_d  = pick(bus.fifo_data_i, '0);
      last_d  = (BEATS == 1);
      rd_d    = 1'b1;
    end else if (xfer) begin
      if (at_last) begin
        state_d = EMPTY;
        last_d  = 1'b0;
      end else begin
        beat_d = beat_nxt;
        data_d = pick(hold_q, beat_nxt);
        last_d = (beat_nxt == LAST_BEAT);
      end
    end
  end

  assign bus.fifo_rd_o   = rd_q;
  assign bus.out_valid_o = (state_q == SENDING);
  assign bus.out_data_o  = data_q;
  assign bus.out_last_o  = last_q;
  assign bus.busy_o      = (state_q == SENDING);

endmodule
